alu_nibble_seq: RTL and testbench

//  Multi-cycle WIDTH-bit add/subtract unit for the ALU. Processes one 4-bit nibble per cycle

---
 rtl/alu_nibble_seq.sv | 136 +++++++++++++
 tb/tb_alu_nibble_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq.sv
// Multi-cycle add/subtract unit: one 4-bit ripple slice processes a nibble per cycle,
// with the carry registered between nibbles. Flags are produced when the last nibble lands.
module alu_nibble_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       nib_a, nib_b;
    logic [4:0]       nib_sum;
    logic             last_nib;

    // The single adder slice, fed by the nibble the counter points at.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (cnt_q == CW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
        nib_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, carry_q};
        last_nib = (cnt_q == CW'(NIB - 1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                for (int i = 0; i < NIB; i++) begin
                    if (cnt_q == CW'(i)) begin
                        result_d[4*i +: 4] = nib_sum[3:0];
                    end
                end
                carry_d = nib_sum[4];
                cnt_d   = cnt_q + CW'(1);
                if (last_nib) begin
                    cout_d  = nib_sum[4];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[3] != a_q[WIDTH-1]);
                    zero_d  = (result_d == '0);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // Operand latches only matter once an operation is accepted, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_CALC) || (state_q == S_DONE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: directed and random add/sub runs on 8- and 16-bit instances,
// compared with an integer-arithmetic reference model.
module tb_alu_nibble_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start8, sub8, rdy8, bsy8, dn8, co8, z8, ov8;
    logic [7:0]  a8, b8, res8;
    logic        start16, sub16, rdy16, bsy16, dn16, co16, z16, ov16;
    logic [15:0] a16, b16, res16;

    int tests = 0;
    int fails = 0;

    alu_nibble_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op_sub(sub8), .a(a8), .b(b8),
        .ready(rdy8), .busy(bsy8), .done(dn8), .result(res8), .cout(co8), .zero(z8), .ovf(ov8)
    );

    alu_nibble_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op_sub(sub16), .a(a16), .b(b16),
        .ready(rdy16), .busy(bsy16), .done(dn16), .result(res16), .cout(co16), .zero(z16), .ovf(ov16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] get_ready(input int w);
        return (w == 8) ? 32'(rdy8) : 32'(rdy16);
    endfunction
    function automatic logic [31:0] get_busy(input int w);
        return (w == 8) ? 32'(bsy8) : 32'(bsy16);
    endfunction
    function automatic logic [31:0] get_done(input int w);
        return (w == 8) ? 32'(dn8) : 32'(dn16);
    endfunction
    function automatic logic [31:0] get_res(input int w);
        return (w == 8) ? 32'(res8) : 32'(res16);
    endfunction
    function automatic logic [31:0] get_cout(input int w);
        return (w == 8) ? 32'(co8) : 32'(co16);
    endfunction
    function automatic logic [31:0] get_zero(input int w);
        return (w == 8) ? 32'(z8) : 32'(z16);
    endfunction
    function automatic logic [31:0] get_ovf(input int w);
        return (w == 8) ? 32'(ov8) : 32'(ov16);
    endfunction

    task automatic drive(input int w, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, input logic sub);
        if (w == 8) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0]; sub8 = sub;
        end else begin
            start16 = s; a16 = av[15:0]; b16 = bv[15:0]; sub16 = sub;
        end
    endtask

    // Reference: plain modular sum for result/carry, true signed range for overflow.
    function automatic void model(input int w, input longint av, input longint bv, input bit sub,
                                  output logic [31:0] res, output bit c, output bit z, output bit o);
        longint m, s, sa, sb, t;
        m   = longint'(1) << w;
        s   = av + (sub ? (m - bv) : bv);
        c   = (s >= m);
        res = 32'(s % m);
        z   = (res == 0);
        sa  = (av >= m / 2) ? av - m : av;
        sb  = (bv >= m / 2) ? bv - m : bv;
        t   = sub ? sa - sb : sa + sb;
        o   = (t < -(m / 2)) || (t >= m / 2);
    endfunction

    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input bit sub,
                          input logic [31:0] er, input bit ec, input bit ez, input bit eo,
                          input string tag);
        int n;
        n = 0;
        while (get_ready(w) == 0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " ready"}, get_ready(w), 32'd1);
        drive(w, 1'b1, av, bv, sub);
        tick();
        // Scramble the operand inputs; the unit must use the latched copies.
        drive(w, 1'b0, $urandom, $urandom, ~sub);
        check({tag, " busy"}, get_busy(w), 32'd1);
        n = 0;
        while (get_done(w) == 0 && n < 12) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(w / 4));
        check({tag, " result"}, get_res(w), er);
        check({tag, " cout"}, get_cout(w), 32'(ec));
        check({tag, " zero"}, get_zero(w), 32'(ez));
        check({tag, " ovf"}, get_ovf(w), 32'(eo));
        tick();
        check({tag, " done pulse"}, get_done(w), 32'd0);
        check({tag, " hold"}, get_res(w), er);
    endtask

    task automatic run_rand(input int w, input string tag);
        logic [31:0] av, bv, er;
        bit sub, ec, ez, eo;
        av  = (w == 8) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 65535));
        bv  = (w == 8) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 65535));
        if ($urandom_range(0, 7) == 0) bv = av;
        sub = 1'($urandom_range(0, 1));
        model(w, longint'(av), longint'(bv), sub, er, ec, ez, eo);
        run_op(w, av, bv, sub, er, ec, ez, eo, tag);
    endtask

    initial begin
        int dcount;
        int dbl;
        bit prev;
        reset = 1'b1;
        drive(8, 1'b0, 0, 0, 1'b0);
        drive(16, 1'b0, 0, 0, 1'b0);
        tick();
        tick();
        check("rst ready", 32'(rdy8), 32'd1);
        check("rst busy", 32'(bsy8), 32'd0);
        check("rst done", 32'(dn8), 32'd0);
        check("rst result", 32'(res8), 32'd0);
        check("rst flags", {29'd0, co8, z8, ov8}, 32'd0);
        check("rst ready16", 32'(rdy16), 32'd1);
        reset = 1'b0;
        tick();

        run_op(8, 32'h3C, 32'h0F, 1'b0, 32'h4B, 1'b0, 1'b0, 1'b0, "add3C0F");
        run_op(8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, "addFF01");
        run_op(8, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b0, 1'b1, "add7F01");
        run_op(8, 32'h80, 32'h01, 1'b1, 32'h7F, 1'b1, 1'b0, 1'b1, "sub8001");
        run_op(8, 32'h05, 32'h07, 1'b1, 32'hFE, 1'b0, 1'b0, 1'b0, "sub0507");
        run_op(8, 32'h22, 32'h22, 1'b1, 32'h00, 1'b1, 1'b1, 1'b0, "sub2222");

        // start and operands wiggled while busy must not disturb the running op
        drive(8, 1'b1, 32'h3C, 32'h0F, 1'b0);
        tick();
        drive(8, 1'b1, 32'hAA, 32'h55, 1'b1);
        dcount = 0;
        while (dn8 == 1'b0 && dcount < 12) begin
            tick();
            dcount++;
        end
        drive(8, 1'b0, 32'hAA, 32'h55, 1'b1);
        check("ign latency", 32'(dcount), 32'd2);
        check("ign result", 32'(res8), 32'h4B);
        tick();
        check("ign idle", 32'(rdy8), 32'd1);
        check("ign done", 32'(dn8), 32'd0);
        check("ign hold", 32'(res8), 32'h4B);

        // start held high: one accept every 4 cycles, done never two cycles in a row
        drive(8, 1'b1, 32'h11, 32'h22, 1'b0);
        dcount = 0;
        dbl = 0;
        prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dn8 && prev) dbl++;
            if (dn8) dcount++;
            prev = dn8;
        end
        drive(8, 1'b0, 32'h11, 32'h22, 1'b0);
        check("b2b dones", 32'(dcount), 32'd3);
        check("b2b double", 32'(dbl), 32'd0);
        check("b2b result", 32'(res8), 32'h33);

        // reset after the first nibble discards the operation
        while (rdy8 == 1'b0) tick();
        drive(8, 1'b1, 32'h3C, 32'h0F, 1'b0);
        tick();
        drive(8, 1'b0, 32'h3C, 32'h0F, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("midrst result", 32'(res8), 32'd0);
        check("midrst ready", 32'(rdy8), 32'd1);
        check("midrst busy", 32'(bsy8), 32'd0);
        check("midrst done", 32'(dn8), 32'd0);
        check("midrst flags", {29'd0, co8, z8, ov8}, 32'd0);
        tick();
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dn8) dcount++;
        end
        check("midrst no done", 32'(dcount), 32'd0);
        check("midrst result after", 32'(res8), 32'd0);

        run_op(16, 32'h0FFF, 32'h0001, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0, "w16 add");

        for (int i = 0; i < 25; i++) run_rand(8, $sformatf("rnd8_%0d", i));
        for (int i = 0; i < 10; i++) run_rand(16, $sformatf("rnd16_%0d", i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
